water_level_encoder: RTL and testbench

Sensor-side encoder for the water-tank level path. Samples three raw conductive level probes (low, mid, high), synchronises and debounces each, checks the probe pattern for physical consistency, and produces the registered 2-bit level code Bit1/Bit0 consumed by the seven-segment level display. Adds a Valid qualifier, a one-cycle Changed pulse and a Fault flag for probe patterns that cannot occur in a real tank.

---
 rtl/water_level_encoder.sv | 166 ++++++++++++++++
 tb/tb_water_level_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/water_level_encoder.sv
// Water-tank level encoder: synchronises and debounces three conductive probes,
// checks the wet pattern for physical consistency and drives a registered 2-bit level code.
module water_level_encoder #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int FAULT_CYCLES    = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic SensorLow,
   input  logic SensorMid,
   input  logic SensorHigh,
   output logic Bit0,
   output logic Bit1,
   output logic Valid,
   output logic Changed,
   output logic Fault
);

   // state   | meaning
   // S_INIT  | startup settle, debouncers filling, code forced to 00
   // S_RUN   | consistent readings drive the code, inconsistent ones counted
   // S_FAULT | inconsistent pattern persisted, waiting for sustained recovery

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SU_W  = $clog2(DEBOUNCE_CYCLES + 3);
   localparam int FC_W  = $clog2(FAULT_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SU_W-1:0]  SU_DONE  = SU_W'(DEBOUNCE_CYCLES + 2);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FAULT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_FAULT
   } state_t;

   logic [2:0]       w_raw;
   logic [2:0]       r_sync1;
   logic [2:0]       r_sync2;
   logic [2:0]       r_st;
   logic [CNT_W-1:0] r_cnt [3];

   logic             w_consistent;
   logic [1:0]       w_level;

   state_t           r_state;
   logic [SU_W-1:0]  r_su;
   logic [FC_W-1:0]  r_fc;
   logic [1:0]       r_code;
   logic             r_valid;
   logic             r_changed;
   logic             r_fault;

   assign w_raw = {SensorHigh, SensorMid, SensorLow};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_st <= '0;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_st[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_st[i]  <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Probes wet from the bottom up; any gap below a wet probe is impossible.
   always_comb begin
      w_consistent = 1'b1;
      w_level      = 2'b00;
      case (r_st)
         3'b000:  w_level = 2'b00;
         3'b001:  w_level = 2'b01;
         3'b011:  w_level = 2'b10;
         3'b111:  w_level = 2'b11;
         default: w_consistent = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_INIT;
         r_su      <= '0;
         r_fc      <= '0;
         r_code    <= 2'b00;
         r_valid   <= 1'b0;
         r_changed <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_valid <= 1'b0;
               r_code  <= 2'b00;
               r_su    <= r_su + SU_W'(1);
               if (r_su + SU_W'(1) == SU_DONE) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_consistent) begin
                  r_code    <= w_level;
                  r_changed <= (w_level != r_code);
                  r_valid   <= 1'b1;
                  r_fc      <= '0;
               end else begin
                  r_valid <= 1'b0;
                  if (r_fc == FC_LAST) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                     r_fc    <= '0;
                  end else begin
                     r_fc <= r_fc + FC_W'(1);
                  end
               end
            end
            S_FAULT: begin
               r_valid <= 1'b0;
               // Recovery needs an unbroken run of consistent readings.
               if (!w_consistent) begin
                  r_fc <= '0;
               end else if (r_fc == FC_LAST) begin
                  r_state   <= S_RUN;
                  r_fault   <= 1'b0;
                  r_fc      <= '0;
                  r_code    <= w_level;
                  r_changed <= (w_level != r_code);
                  r_valid   <= 1'b1;
               end else begin
                  r_fc <= r_fc + FC_W'(1);
               end
            end
            default: begin
               r_state <= S_INIT;
            end
         endcase
      end
   end

   assign Bit0    = r_code[0];
   assign Bit1    = r_code[1];
   assign Valid   = r_valid;
   assign Changed = r_changed;
   assign Fault   = r_fault;

endmodule

// File: tb/tb_water_level_encoder.sv
// Bench for water_level_encoder: directed scenarios plus random probe traffic,
// every cycle compared against a window-based behavioural model.
module tb_water_level_encoder;

   localparam int D = 8;
   localparam int F = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic SensorLow = 1'b0;
   logic SensorMid = 1'b0;
   logic SensorHigh = 1'b0;
   logic Bit0, Bit1, Valid, Changed, Fault;

   int total = 0;
   int bad = 0;

   water_level_encoder #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
      .clk(clk), .reset(reset),
      .SensorLow(SensorLow), .SensorMid(SensorMid), .SensorHigh(SensorHigh),
      .Bit0(Bit0), .Bit1(Bit1), .Valid(Valid), .Changed(Changed), .Fault(Fault)
   );

   always #5 clk = ~clk;

   // Reference model: a probe's stable value flips once its last D synchronised
   // samples all disagree with it; the level is the count of wet probes.
   logic [2:0] m_sync1, m_sync2, m_st;
   logic [2:0] m_hist[$];
   int         m_edges, m_bad_run, m_good_run;
   bit         m_fault_mode;
   logic [1:0] e_code;
   logic       e_valid, e_changed, e_fault;

   function automatic bit is_consistent(input logic [2:0] p);
      return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
   endfunction

   function automatic logic [1:0] level_of(input logic [2:0] p);
      return 2'($countones(p));
   endfunction

   always @(posedge clk or posedge reset) begin : model
      logic [2:0] p;
      bit all_diff;
      if (reset) begin
         m_sync1 = '0; m_sync2 = '0; m_st = '0;
         m_hist.delete();
         m_edges = 0; m_bad_run = 0; m_good_run = 0; m_fault_mode = 0;
         e_code = 2'b00; e_valid = 0; e_changed = 0; e_fault = 0;
      end else begin
         p = m_st;
         e_changed = 0;
         if (m_edges < D + 2) begin
            e_valid = 0;
            e_code = 2'b00;
         end else if (!m_fault_mode) begin
            if (is_consistent(p)) begin
               e_changed = (level_of(p) != e_code);
               e_code = level_of(p);
               e_valid = 1;
               m_bad_run = 0;
            end else begin
               e_valid = 0;
               m_bad_run++;
               if (m_bad_run == F) begin
                  m_fault_mode = 1; e_fault = 1; m_bad_run = 0; m_good_run = 0;
               end
            end
         end else begin
            e_valid = 0;
            if (is_consistent(p)) m_good_run++;
            else m_good_run = 0;
            if (m_good_run == F) begin
               m_fault_mode = 0; e_fault = 0; m_good_run = 0;
               e_changed = (level_of(p) != e_code);
               e_code = level_of(p);
               e_valid = 1;
            end
         end
         m_edges++;
         m_hist.push_back(m_sync2);
         if (m_hist.size() > D) void'(m_hist.pop_front());
         if (m_hist.size() == D) begin
            for (int b = 0; b < 3; b++) begin
               all_diff = 1;
               for (int k = 0; k < D; k++) if (m_hist[k][b] == m_st[b]) all_diff = 0;
               if (all_diff) m_st[b] = ~m_st[b];
            end
         end
         m_sync2 = m_sync1;
         m_sync1 = {SensorHigh, SensorMid, SensorLow};
      end
   end

   task automatic set_probes(input logic [2:0] p);
      {SensorHigh, SensorMid, SensorLow} = p;
   endtask

   task automatic test_reset();
      set_probes(3'b000);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({Bit1, Bit0, Valid, Changed, Fault} !== 5'b00000) begin
         bad++; $display("FAIL reset_state got %b want 00000", {Bit1, Bit0, Valid, Changed, Fault});
      end
   endtask

   task automatic test_startup();
      int n_chg = 0;
      reset = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL startup_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         total++;
         if (Valid !== (n >= 11)) begin
            bad++; $display("FAIL startup_valid n=%0d got %b want %b", n, Valid, (n >= 11));
         end
         if (Changed === 1'b1) n_chg++;
      end
      total++;
      if (n_chg != 0 || {Bit1, Bit0} !== 2'b00) begin
         bad++; $display("FAIL startup_code changed=%0d code=%b want changed=0 code=00", n_chg, {Bit1, Bit0});
      end
   endtask

   task automatic test_single_step();
      int first_code = -1, chg_edge = -1, n_chg = 0, n_inval = 0;
      set_probes(3'b001);
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL step_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (Changed === 1'b1) begin n_chg++; chg_edge = n; end
         if (Valid !== 1'b1) n_inval++;
         if (first_code < 0 && {Bit1, Bit0} === 2'b01) first_code = n;
      end
      total++;
      if (first_code != D + 3) begin
         bad++; $display("FAIL step_latency got edge %0d want %0d", first_code, D + 3);
      end
      total++;
      if (n_chg != 1 || chg_edge != D + 3 || n_inval != 0) begin
         bad++; $display("FAIL step_changed pulses=%0d at %0d invalid=%0d want 1 at %0d invalid=0", n_chg, chg_edge, n_inval, D + 3);
      end
   endtask

   task automatic test_fault();
      int first_inval = -1, first_fault = -1, first_clear = -1, n_chg = 0, n_badcode = 0;
      set_probes(3'b100);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL fault_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (first_inval < 0 && Valid === 1'b0) first_inval = n;
         if (first_fault < 0 && Fault === 1'b1) first_fault = n;
         if (Changed === 1'b1) n_chg++;
         if ({Bit1, Bit0} !== 2'b01) n_badcode++;
      end
      total++;
      if (first_inval != D + 3 || first_fault != D + 2 + F) begin
         bad++; $display("FAIL fault_raise valid_fall=%0d fault_rise=%0d want %0d and %0d", first_inval, first_fault, D + 3, D + 2 + F);
      end
      set_probes(3'b001);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL recover_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (first_clear < 0 && Fault === 1'b0 && Valid === 1'b1) first_clear = n;
         if (Changed === 1'b1) n_chg++;
         if ({Bit1, Bit0} !== 2'b01) n_badcode++;
      end
      total++;
      if (first_clear != D + 2 + F || n_chg != 0 || n_badcode != 0) begin
         bad++; $display("FAIL fault_recover clear=%0d changed=%0d badcode=%0d want %0d, 0, 0", first_clear, n_chg, n_badcode, D + 2 + F);
      end
   endtask

   task automatic test_glitch();
      int n_chg = 0, n_badcode = 0, first_code = -1;
      set_probes(3'b011);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 7) set_probes(3'b001);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL glitch_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (Changed === 1'b1) n_chg++;
         if ({Bit1, Bit0} !== 2'b01) n_badcode++;
      end
      total++;
      if (n_chg != 0 || n_badcode != 0) begin
         bad++; $display("FAIL glitch_filtered changed=%0d badcode=%0d want 0 0", n_chg, n_badcode);
      end
      set_probes(3'b011);
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL mid_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (first_code < 0 && {Bit1, Bit0} === 2'b10) first_code = n;
      end
      total++;
      if (first_code != D + 3) begin
         bad++; $display("FAIL mid_latency got edge %0d want %0d", first_code, D + 3);
      end
   endtask

   task automatic test_multi_band();
      int first_code = -1, n_chg = 0, n_fault = 0, n_mid = 0;
      set_probes(3'b000);
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL drain_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
      end
      set_probes(3'b111);
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL jump_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (first_code < 0 && {Bit1, Bit0} === 2'b11) first_code = n;
         if (Changed === 1'b1) n_chg++;
         if (Fault !== 1'b0) n_fault++;
         if ({Bit1, Bit0} === 2'b01 || {Bit1, Bit0} === 2'b10) n_mid++;
      end
      total++;
      if (first_code != D + 3 || n_chg != 1 || n_fault != 0 || n_mid != 0) begin
         bad++; $display("FAIL jump_direct edge=%0d changed=%0d fault=%0d intermediate=%0d want %0d 1 0 0", first_code, n_chg, n_fault, n_mid, D + 3);
      end
   endtask

   task automatic test_reset_in_fault();
      int n_early = 0;
      set_probes(3'b011);
      repeat (14) @(negedge clk);
      set_probes(3'b110);
      repeat (18) @(negedge clk);
      total++;
      if ({Bit1, Bit0, Fault, Valid} !== 4'b1010) begin
         bad++; $display("FAIL in_fault code=%b fault=%b valid=%b want 10 1 0", {Bit1, Bit0}, Fault, Valid);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({Bit1, Bit0, Valid, Changed, Fault} !== 5'b00000) begin
         bad++; $display("FAIL async_reset got %b want 00000", {Bit1, Bit0, Valid, Changed, Fault});
      end
      repeat (3) @(negedge clk);
      set_probes(3'b011);
      reset = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         total++;
         if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
            bad++; $display("FAIL restart_model n=%0d got %b want %b", n, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
         end
         if (n <= D + 2 && (Valid !== 1'b0 || Changed !== 1'b0)) n_early++;
      end
      total++;
      if (n_early != 0 || Valid !== 1'b1 || {Bit1, Bit0} !== 2'b10) begin
         bad++; $display("FAIL restart_init early=%0d valid=%b code=%b want 0 1 10", n_early, Valid, {Bit1, Bit0});
      end
   endtask

   task automatic test_random();
      logic [2:0] good [4];
      logic [2:0] pat;
      int hold;
      good[0] = 3'b000; good[1] = 3'b001; good[2] = 3'b011; good[3] = 3'b111;
      reset = 1'b1;
      set_probes(3'b000);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int seg = 0; seg < 70; seg++) begin
         if ($urandom_range(0, 3) == 0) pat = 3'($urandom_range(0, 7));
         else pat = good[$urandom_range(0, 3)];
         set_probes(pat);
         hold = $urandom_range(1, D + F + 6);
         for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            total++;
            if ({Bit1, Bit0, Valid, Changed, Fault} !== {e_code, e_valid, e_changed, e_fault}) begin
               bad++; $display("FAIL random_model seg=%0d c=%0d got %b want %b", seg, c, {Bit1, Bit0, Valid, Changed, Fault}, {e_code, e_valid, e_changed, e_fault});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_single_step();
      test_fault();
      test_glitch();
      test_multi_band();
      test_reset_in_fault();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
